// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and memory freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int JFLUSH_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_src1_addr,
  input  logic [2:0]  id_src2_addr,
  input  logic        id_src1_used,
  input  logic        id_src2_used,
  input  logic        idexe_rd_mem_en,
  input  logic        idexe_wb_enable,
  input  logic [2:0]  idexe_wb_dest,
  input  logic        jump_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idexe_en,
  output logic        exemem_en,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    JUMP_FLUSH = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [2:0] scnt, scnt_nx;
  logic [1:0] jcnt, jcnt_nx;
  logic       hz;

  assign hz = idexe_rd_mem_en && idexe_wb_enable && (idexe_wb_dest != 3'd0) &&
              ((id_src1_used && (id_src1_addr == idexe_wb_dest)) ||
               (id_src2_used && (id_src2_addr == idexe_wb_dest)));

  always_comb begin
    state_nx    = state;
    scnt_nx     = scnt;
    jcnt_nx     = jcnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idexe_en    = 1'b1;
    exemem_en   = 1'b1;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    if (mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idexe_en  = 1'b0;
      exemem_en = 1'b0;
      state_nx  = MEM_WAIT;
    end else begin
      case (state)
        JUMP_FLUSH: begin
          ifid_flush = 1'b1;
          jcnt_nx    = jcnt - 2'd1;
          state_nx   = (jcnt == 2'd1) ? RUN : JUMP_FLUSH;
        end
        LOAD_STALL: begin
          if (jump_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            scnt_nx     = '0;
            jcnt_nx     = 2'(JFLUSH_EXTRA);
            state_nx    = (JFLUSH_EXTRA == 0) ? RUN : JUMP_FLUSH;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
            scnt_nx     = scnt - 3'd1;
            state_nx    = (scnt == 3'd1) ? RUN : LOAD_STALL;
          end
        end
        default: begin
          // MEM_WAIT release evaluates like RUN; with no new event it resumes
          // whichever stall/flush the freeze interrupted.
          if (jump_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            scnt_nx     = '0;
            jcnt_nx     = 2'(JFLUSH_EXTRA);
            state_nx    = (JFLUSH_EXTRA == 0) ? RUN : JUMP_FLUSH;
          end else if (hz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
            scnt_nx     = 3'(LOAD_LAT - 1);
            jcnt_nx     = '0;
            state_nx    = (LOAD_LAT == 1) ? RUN : LOAD_STALL;
          end else if (state == MEM_WAIT) begin
            state_nx = (scnt != 3'd0) ? LOAD_STALL :
                       (jcnt != 2'd0) ? JUMP_FLUSH : RUN;
          end
        end
      endcase
    end
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idexe_en    = 1'b0;
      exemem_en   = 1'b0;
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      scnt  <= '0;
      jcnt  <= '0;
    end else begin
      state <= state_nx;
      scnt  <= scnt_nx;
      jcnt  <= jcnt_nx;
    end
  end

  assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + 16'd1;
      if (jump_taken && ((state == RUN) || (state == LOAD_STALL)) && (flush_q != '1))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: four parameterisations driven in parallel, checked
// against a pending-cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mb, jt, rdm, wbe, u1, u2;
  logic [2:0] dest, a1, a2;

  logic [N-1:0] pc_v, ifid_v, idexe_v, exemem_v, iff_v, idf_v;
  logic [1:0]   st_v [N];
  logic [15:0]  sc_v [N];
  logic [15:0]  fe_v [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LL = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 7;
    localparam int JX = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 0 : 3;
    pipe_hazard_ctrl #(.LOAD_LAT(LL), .JFLUSH_EXTRA(JX)) u_dut (
      .clk(clk), .rst(rst),
      .id_src1_addr(a1), .id_src2_addr(a2),
      .id_src1_used(u1), .id_src2_used(u2),
      .idexe_rd_mem_en(rdm), .idexe_wb_enable(wbe), .idexe_wb_dest(dest),
      .jump_taken(jt), .mem_busy(mb),
      .pc_en(pc_v[g]), .ifid_en(ifid_v[g]), .idexe_en(idexe_v[g]), .exemem_en(exemem_v[g]),
      .ifid_flush(iff_v[g]), .idexe_flush(idf_v[g]), .state_o(st_v[g]),
      .stall_cycles(sc_v[g]), .flush_events(fe_v[g])
    );
  end

  int m_ll [N] = '{1, 3, 2, 7};
  int m_jx [N] = '{1, 1, 0, 3};

  // Reference: remaining stall cycles, remaining flush-only cycles, frozen flag.
  int sl [N];
  int fl [N];
  bit wt [N];
  int sc [N];
  int fe [N];
  int pcz [N];
  int ifz [N];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hz_f();
    return rdm && wbe && (dest != 3'd0) &&
           ((u1 && (a1 == dest)) || (u2 && (a2 == dest)));
  endfunction

  task automatic set_in(input bit r, input bit m, input bit j, input bit rd, input bit wb,
                        input logic [2:0] d, input logic [2:0] s1, input bit us1,
                        input logic [2:0] s2, input bit us2);
    rst = r; mb = m; jt = j; rdm = rd; wbe = wb;
    dest = d; a1 = s1; u1 = us1; a2 = s2; u2 = us2;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
  endtask

  task automatic hazard_r3();
    set_in(0, 0, 0, 1, 1, 3'd3, 3'd3, 1, 3'd5, 0);
  endtask

  task automatic clear_tallies();
    for (int i = 0; i < N; i++) begin
      pcz[i] = 0;
      ifz[i] = 0;
    end
  endtask

  // Inputs are already driven at the falling edge; outputs are checked 1 ns later.
  task automatic cyc(input bit chk);
    int nsl [N];
    int nfl [N];
    bit nwt [N];
    logic [7:0] e;
    logic [1:0] st;
    bit p, fi, fx, ie, hz;
    #1;
    hz = hz_f();
    for (int i = 0; i < N; i++) begin
      st = rst ? 2'd0 : wt[i] ? 2'd3 : (sl[i] > 0) ? 2'd1 : (fl[i] > 0) ? 2'd2 : 2'd0;
      nsl[i] = sl[i]; nfl[i] = fl[i]; nwt[i] = 1'b0;
      p = 1; ie = 1; fi = 0; fx = 0;
      if (rst) begin
        p = 0; ie = 0; fi = 1; fx = 1;
        nsl[i] = 0; nfl[i] = 0;
      end else if (mb) begin
        p = 0; ie = 0; nwt[i] = 1'b1;
      end else if (!wt[i] && sl[i] > 0) begin
        if (jt) begin
          fi = 1; fx = 1; nsl[i] = 0; nfl[i] = m_jx[i];
        end else begin
          p = 0; fx = 1; nsl[i] = sl[i] - 1;
        end
      end else if (!wt[i] && fl[i] > 0) begin
        fi = 1; nfl[i] = fl[i] - 1;
      end else if (jt) begin
        fi = 1; fx = 1; nsl[i] = 0; nfl[i] = m_jx[i];
      end else if (hz) begin
        p = 0; fx = 1; nsl[i] = m_ll[i] - 1; nfl[i] = 0;
      end
      // pc_en, ifid_en, idexe_en, exemem_en, ifid_flush, idexe_flush, state
      e = {p, p, ie && !rst ? 1'b1 : (rst ? 1'b0 : ie), ie, fi, fx, st};
      if (mb && !rst) e[5] = 1'b0;
      if (chk) begin
        check($sformatf("out%0d", i),
              {8'd0, pc_v[i], ifid_v[i], idexe_v[i], exemem_v[i], iff_v[i], idf_v[i], st_v[i]},
              {8'd0, e});
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("stallcnt%0d", i), sc_v[i], 16'(sc[i]));
        check($sformatf("flushcnt%0d", i), fe_v[i], 16'(fe[i]));
`else
        check($sformatf("stallcnt%0d", i), sc_v[i], 16'd0);
        check($sformatf("flushcnt%0d", i), fe_v[i], 16'd0);
`endif
        if (!pc_v[i]) pcz[i]++;
        if (iff_v[i]) ifz[i]++;
      end
      if (rst) begin
        sc[i] = 0; fe[i] = 0;
      end else begin
        if (!p && sc[i] < 65535) sc[i]++;
        if (jt && (st == 2'd0 || st == 2'd1) && fe[i] < 65535) fe[i]++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      sl[i] = nsl[i]; fl[i] = nfl[i]; wt[i] = nwt[i];
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sl[i] = 0; fl[i] = 0; wt[i] = 0; sc[i] = 0; fe[i] = 0;
    end
    set_in(1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    @(negedge clk);
    #1;
    check("rst_enables", {12'd0, pc_v[0], ifid_v[0], idexe_v[0], exemem_v[0]}, 16'd0);
    check("rst_flushes", {14'd0, iff_v[0], idf_v[0]}, 16'h0003);
    check("rst_state", {14'd0, st_v[0]}, 16'd0);
    @(negedge clk);
    run(2);
    idle();
    run(2);

    // Single load-use hazard: stall length equals LOAD_LAT per instance.
    clear_tallies();
    hazard_r3();
    cyc(1);
    idle();
    run(9);
    check("stall_len_ll1", 16'(pcz[0]), 16'd1);
    check("stall_len_ll3", 16'(pcz[1]), 16'd3);
    check("stall_len_ll7", 16'(pcz[3]), 16'd7);

    // Jump pulse: IF/ID flush lasts JFLUSH_EXTRA+1 cycles.
    clear_tallies();
    set_in(0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    cyc(1);
    idle();
    run(5);
    check("jflush_len_jx1", 16'(ifz[0]), 16'd2);
    check("jflush_len_jx0", 16'(ifz[2]), 16'd1);
    check("jflush_len_jx3", 16'(ifz[3]), 16'd4);

    // Memory freeze for 4 cycles in the middle of a load stall.
    clear_tallies();
    hazard_r3();
    cyc(1);
    set_in(0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    run(4);
    idle();
    run(9);
    check("freeze_stall_ll3", 16'(pcz[1]), 16'd7);

    // Hazard, jump and freeze together; then jump only after freeze; then R0 load.
    set_in(0, 1, 1, 1, 1, 3'd4, 3'd4, 1, 3'd4, 1);
    run(2);
    set_in(0, 0, 1, 1, 1, 3'd4, 3'd4, 1, 3'd4, 1);
    cyc(1);
    idle();
    run(5);
    set_in(0, 0, 0, 1, 1, 3'd0, 3'd0, 1, 3'd0, 1);
    #1;
    check("r0_no_stall", {12'd0, pc_v}, 16'h000F);
    cyc(1);
    idle();
    run(2);

    // Reset pulse aborts a load stall.
    hazard_r3();
    cyc(1);
    set_in(1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    run(2);
    idle();
    #1;
    check("post_rst_state", {14'd0, st_v[1]}, 16'd0);
    run(3);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      logic [2:0] d;
      d = 3'($urandom_range(0, 7));
      set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), d,
             ($urandom_range(0, 1) == 1) ? d : 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 2) == 0) ? d : 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      cyc(1);
    end
    idle();
    run(10);

`ifdef HAZARD_PERF_CNT_EN
    set_in(0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    for (int k = 0; k < 70000; k++) cyc(0);
    idle();
    #1;
    check("stall_saturate", sc_v[0], 16'hFFFF);
    run(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL take parameter LOAD_LAT, default 1 (range 1..7), as the number of ID-stage stall cycles inserted per load-use hazard.
REQ-002 The block SHALL take parameter JFLUSH_EXTRA, default 1 (range 0..3), as the extra IF/ID flush cycles after a taken jump.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports id_src1_addr and id_src2_addr, input, 3 bits each: ID-stage source register numbers.
REQ-006 Ports id_src1_used and id_src2_used, input, 1 bit each: the corresponding ID-stage source is read.
REQ-007 Ports idexe_rd_mem_en, idexe_wb_enable, input, 1 bit each, and idexe_wb_dest, input, 3 bits: load/writeback status of the instruction in EXE.
REQ-008 Port jump_taken, input, 1 bit: jump resolved taken in EXE this cycle.
REQ-009 Port mem_busy, input, 1 bit: data memory not ready; the pipeline must freeze.
REQ-010 Ports pc_en, ifid_en, idexe_en and exemem_en, output, 1 bit each: register enables.
REQ-011 Ports ifid_flush and idexe_flush, output, 1 bit each: synchronous clears inserting bubbles.
REQ-012 Port state_o, output, 2 bits: current state (RUN=0, LOAD_STALL=1, JUMP_FLUSH=2, MEM_WAIT=3).
REQ-013 Ports stall_cycles and flush_events, output, 16 bits each: performance counters.

Function
REQ-014 hz SHALL equal idexe_rd_mem_en AND idexe_wb_enable AND idexe_wb_dest!=0 AND ((id_src1_used AND id_src1_addr==idexe_wb_dest) OR (id_src2_used AND id_src2_addr==idexe_wb_dest)).
REQ-015 Outputs SHALL be combinational from state, counter and current inputs (zero-cycle response); priority: mem_busy > jump_taken > hz.
REQ-016 When mem_busy=1 in any state: all four enables=0, flushes=0, next state=MEM_WAIT, and the stall counter and jump-flush counter SHALL hold.
REQ-017 MEM_WAIT with mem_busy=0 SHALL produce RUN outputs for that cycle and return to RUN, or to LOAD_STALL or JUMP_FLUSH if either counter is nonzero.
REQ-018 RUN with jump_taken=1: pc_en=1, other enables=1, ifid_flush=1, idexe_flush=1; next state JUMP_FLUSH with jcnt=JFLUSH_EXTRA, or RUN if JFLUSH_EXTRA=0.
REQ-019 JUMP_FLUSH: all enables=1, ifid_flush=1, idexe_flush=0; jcnt decrements; exit to RUN when jcnt==1; jump_taken and hz ignored in this state.
REQ-020 RUN with hz=1, no jump: pc_en=0, ifid_en=0, idexe_flush=1, idexe_en=1, exemem_en=1; next state LOAD_STALL with scnt=LOAD_LAT-1, or RUN if LOAD_LAT=1.
REQ-021 LOAD_STALL: same outputs as REQ-020; scnt decrements; exit to RUN when scnt==1; jump_taken here SHALL take REQ-018 behaviour and clear scnt.
REQ-022 RUN with no event: all enables=1, flushes=0.

Reset
REQ-023 While rst=1: state=RUN, scnt=jcnt=0, counters=0, pc_en=ifid_en=idexe_en=exemem_en=0, ifid_flush=idexe_flush=1.
REQ-024 Reset asserted mid-stall or mid-flush SHALL abort it immediately; the first cycle after release SHALL be RUN with no pending stall.

Configuration
REQ-025 With HAZARD_PERF_CNT_EN defined: stall_cycles SHALL count cycles with pc_en=0 and flush_events SHALL count RUN/LOAD_STALL cycles with jump_taken=1; both saturate at 16'hFFFF.
REQ-026 Without HAZARD_PERF_CNT_EN: stall_cycles and flush_events SHALL be constant 0, and no counter flops SHALL exist.

Verification
REQ-027 LOAD_LAT=1: idexe load to R3, ID reads R3 via src1 -> one cycle pc_en=0, idexe_flush=1; next cycle all enables=1.
REQ-028 LOAD_LAT=3: same hazard -> pc_en=0 for exactly 3 consecutive cycles; state_o=1 for cycles 2-3.
REQ-029 JFLUSH_EXTRA=1: jump_taken pulse -> ifid_flush=1 for 2 cycles, idexe_flush=1 for the first cycle only, pc_en=1 throughout.
REQ-030 mem_busy=1 for 4 cycles during LOAD_STALL (LOAD_LAT=3) -> all enables=0 for 4 cycles, state_o=3, then the remaining stall cycles complete.
REQ-031 Simultaneous hz, jump_taken and mem_busy=1 -> freeze first; after mem_busy drops -> jump flush, no stall; dest R0 load -> no stall.
REQ-032 rst pulse during LOAD_STALL -> flushes=1 while reset is asserted, state_o=0 after release; with HAZARD_PERF_CNT_EN, 70000 stall cycles -> stall_cycles=16'hFFFF.
